// File: rtl/spike_rate_encoder.sv
// Rate-coding spike encoder: one intensity sample becomes a spike train over WINDOW steps.
// Define SPIKE_ENC_LFSR_EN for the stochastic LFSR generator; the default is a deterministic accumulator.
module spike_rate_encoder #(
    parameter int          DATA_W    = 8,
    parameter int          WINDOW    = 20,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [DATA_W-1:0]            in_intensity,
    input  logic                         step_en,
    output logic                         spike_out,
    output logic                         busy,
    output logic                         window_done,
    output logic [$clog2(WINDOW+1)-1:0]  spike_count
);

    localparam int CW = $clog2(WINDOW + 1);
    localparam logic [CW-1:0] LAST_STEP = CW'(WINDOW - 1);
    localparam logic [CW-1:0] MAX_COUNT = CW'(WINDOW);

    if (WINDOW < 1) begin : g_bad_window
        $error("spike_rate_encoder: WINDOW must be >= 1");
    end
    if (LFSR_SEED == 16'h0) begin : g_bad_seed
        $error("spike_rate_encoder: LFSR_SEED must be nonzero");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic              accept;
    logic              step;
    logic              spike_d;
    logic [DATA_W-1:0] inten_q;
    logic [CW-1:0]     step_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        step    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    accept  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (step_en) begin
                    step = 1'b1;
                    if (step_cnt == LAST_STEP) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign in_ready    = (state_q == IDLE);
    assign busy        = (state_q == RUN);
    assign window_done = (state_q == DONE);

`ifdef SPIKE_ENC_LFSR_EN
    if (DATA_W > 16) begin : g_bad_width
        $error("spike_rate_encoder: DATA_W must be <= 16 with the LFSR generator");
    end

    logic [15:0] lfsr;
    logic [15:0] lfsr_next;

    // Galois form, taps x^16+x^14+x^13+x^11+1, shifting toward bit 0
    assign lfsr_next = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
    assign spike_d   = (lfsr[DATA_W-1:0] < inten_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr <= LFSR_SEED;
        end else if (step) begin
            lfsr <= lfsr_next;
        end
    end
`else
    logic [DATA_W-1:0] acc;
    logic [DATA_W-1:0] acc_sum;

    // The carry out of the phase accumulator is the spike
    assign {spike_d, acc_sum} = {1'b0, acc} + {1'b0, inten_q};

    always_ff @(posedge clk) begin
        if (rst) begin
            acc <= '0;
        end else if (accept) begin
            acc <= '0;
        end else if (step) begin
            acc <= acc_sum;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            inten_q     <= '0;
            step_cnt    <= '0;
            spike_out   <= 1'b0;
            spike_count <= '0;
        end else begin
            spike_out <= 1'b0;
            if (accept) begin
                inten_q     <= in_intensity;
                step_cnt    <= '0;
                spike_count <= '0;
            end else if (step) begin
                step_cnt  <= step_cnt + 1'b1;
                spike_out <= spike_d;
                if (spike_d && (spike_count != MAX_COUNT)) begin
                    spike_count <= spike_count + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_spike_rate_encoder.sv
// Directed self-checking bench for spike_rate_encoder (DATA_W=8, WINDOW=20).
// Covers the accumulator build by default and the LFSR build when SPIKE_ENC_LFSR_EN is defined.
`timescale 1ns/1ps
module tb_spike_rate_encoder;

    localparam int          DATA_W = 8;
    localparam int          WINDOW = 20;
    localparam logic [15:0] SEED   = 16'hACE1;
    localparam int          CW     = $clog2(WINDOW + 1);

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [DATA_W-1:0] in_intensity = '0;
    logic              step_en = 1'b0;
    logic              spike_out;
    logic              busy;
    logic              window_done;
    logic [CW-1:0]     spike_count;

    int tests = 0;
    int failed = 0;

    // Results collected by run_window
    logic [WINDOW-1:0] mask;
    int                cnt_done;
    int                cycles;
    int                cnt_idle;
    logic              rdy_idle;
    logic              wd_idle;
    logic              stray;
    logic              acc_busy;
    logic              acc_rdy;

    logic [15:0]       m_lfsr;

    spike_rate_encoder #(
        .DATA_W   (DATA_W),
        .WINDOW   (WINDOW),
        .LFSR_SEED(SEED)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_intensity(in_intensity),
        .step_en     (step_en),
        .spike_out   (spike_out),
        .busy        (busy),
        .window_done (window_done),
        .spike_count (spike_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        step_en = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        m_lfsr = SEED;
    endtask

    // Accept one sample, step until window_done (bounded), then one cycle into IDLE.
    task automatic run_window(input logic [DATA_W-1:0] inten, input bit toggle, input bit poke);
        int  ts;
        logic s;
        bit  seen;
        mask = '0;
        stray = 1'b0;
        ts = 0;
        cycles = 0;
        seen = 1'b0;
        in_valid = 1'b1;
        in_intensity = inten;
        step_en = 1'b0;
        tick();
        acc_busy = busy;
        acc_rdy = in_ready;
        in_valid = 1'b0;
        step_en = toggle ? 1'b0 : 1'b1;
        while (!seen && cycles < 200) begin
            s = step_en;
            tick();
            cycles++;
            if (s) begin
                if (ts < WINDOW) mask[ts] = spike_out;
                ts++;
            end else begin
                stray = stray | spike_out;
            end
            if (window_done) seen = 1'b1;
            if (poke && cycles == 5) begin
                in_valid = 1'b1;
                in_intensity = 8'd64;
            end else begin
                in_valid = 1'b0;
            end
            if (toggle) step_en = ~step_en;
        end
        cnt_done = int'(spike_count);
        in_valid = 1'b0;
        step_en = 1'b0;
        tick();
        cnt_idle = int'(spike_count);
        rdy_idle = in_ready;
        wd_idle = window_done;
    endtask

    function automatic logic [15:0] adv(input logic [15:0] l);
        return {1'b0, l[15:1]} ^ (l[0] ? 16'hB400 : 16'h0000);
    endfunction

    // Reference mask for a fully stepped window; advances the shared model state
    function automatic logic [WINDOW-1:0] model_mask(input logic [DATA_W-1:0] inten);
        logic [WINDOW-1:0] m;
        m = '0;
        for (int t = 0; t < WINDOW; t++) begin
            m[t] = (m_lfsr[DATA_W-1:0] < inten);
            m_lfsr = adv(m_lfsr);
        end
        return m;
    endfunction

    initial begin
        logic [WINDOW-1:0] exp_m;
        logic [WINDOW-1:0] first_m;
        int                wd_seen;

        do_reset();
        tick();
        chk("rst_in_ready", in_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_window_done", window_done, 0);
        chk("rst_spike_out", spike_out, 0);
        chk("rst_spike_count", spike_count, 0);

`ifndef SPIKE_ENC_LFSR_EN
        run_window(8'd128, 1'b0, 1'b0);
        chk("i128_accept_busy", acc_busy, 1);
        chk("i128_accept_ready", acc_rdy, 0);
        chk("i128_mask", mask, 20'hAAAAA);
        chk("i128_count", cnt_done, 10);
        chk("i128_done_edges", cycles, 20);
        chk("i128_stray", stray, 0);
        chk("i128_idle_ready", rdy_idle, 1);
        chk("i128_single_pulse", wd_idle, 0);
        chk("i128_count_hold", cnt_idle, 10);

        run_window(8'd255, 1'b0, 1'b0);
        chk("i255_mask", mask, 20'hFFFFE);
        chk("i255_count", cnt_done, 19);

        run_window(8'd0, 1'b0, 1'b0);
        chk("i0_mask", mask, 20'h00000);
        chk("i0_count", cnt_done, 0);
        chk("i0_done_edges", cycles, 20);

        run_window(8'd128, 1'b1, 1'b0);
        chk("gate_done_edges", cycles, 40);
        chk("gate_count", cnt_done, 10);
        chk("gate_mask", mask, 20'hAAAAA);
        chk("gate_stray", stray, 0);

        run_window(8'd128, 1'b0, 1'b1);
        chk("poke_count", cnt_done, 10);
        chk("poke_mask", mask, 20'hAAAAA);
        chk("poke_done_edges", cycles, 20);

        in_valid = 1'b1;
        in_intensity = 8'd128;
        tick();
        in_valid = 1'b0;
        step_en = 1'b1;
        wd_seen = 0;
        repeat (7) begin
            tick();
            if (window_done) wd_seen++;
        end
        chk("mid_count_ts7", spike_count, 3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        step_en = 1'b0;
        chk("mid_in_ready", in_ready, 1);
        chk("mid_busy", busy, 0);
        chk("mid_count", spike_count, 0);
        chk("mid_spike_out", spike_out, 0);
        repeat (3) begin
            if (window_done) wd_seen++;
            tick();
        end
        chk("mid_no_done", wd_seen, 0);

        run_window(8'd255, 1'b0, 1'b0);
        chk("post_mid_mask", mask, 20'hFFFFE);
        chk("post_mid_count", cnt_done, 19);
        chk("post_mid_edges", cycles, 20);
`else
        run_window(8'd0, 1'b0, 1'b0);
        exp_m = model_mask(8'd0);
        chk("lfsr_i0_mask", mask, 0);
        chk("lfsr_i0_count", cnt_done, 0);
        chk("lfsr_i0_edges", cycles, 20);

        run_window(8'd255, 1'b0, 1'b0);
        exp_m = model_mask(8'd255);
        chk("lfsr_i255_mask", mask, exp_m);
        chk("lfsr_i255_ge19", (cnt_done >= 19), 1);
        chk("lfsr_i255_count", cnt_done, $countones(exp_m));

        do_reset();
        run_window(8'd100, 1'b0, 1'b0);
        exp_m = model_mask(8'd100);
        first_m = mask;
        chk("lfsr_i100a_mask", mask, exp_m);
        chk("lfsr_i100a_count", cnt_done, $countones(exp_m));

        do_reset();
        run_window(8'd100, 1'b0, 1'b0);
        exp_m = model_mask(8'd100);
        chk("lfsr_i100b_repeat", mask, first_m);
        chk("lfsr_i100b_mask", mask, exp_m);
        chk("lfsr_i100b_count", cnt_done, $countones(exp_m));
        chk("lfsr_i100b_ready", rdy_idle, 1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
